mdio_master: RTL and testbench

- Clause 22 MDIO management master for the RGMII PHY, in the 125 MHz `clk` domain next to the MAC core.
- Drives the PHY management pins (MDC, MDIO tristate) on the board-level `rgmii_mdio_a` path, which has no driver today.
- Takes single register read/write commands over a valid/ready handshake and returns read data with a one-cycle valid strobe.
- Used by bring-up logic to configure the PHY once `phy_reset_n` is released.

---
 rtl/mdio_pkg.sv | 39 +++
 rtl/mdio_mdc_gen.sv | 42 ++++
 rtl/mdio_master.sv | 158 +++++++++++++++
 tb/tb_mdio_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause 22 MDIO management master.
// Optional feature macro used by the top level: MDIO_PREAMBLE_SUPPRESS_EN.
package mdio_pkg;

  // Clause 22 frame field encodings
  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

  // Bit counts per frame section, sized to match the per-state bit counter
  localparam logic [5:0] MDIO_PREAMBLE_BITS = 6'd32;
  localparam logic [5:0] MDIO_FRAME_BITS    = 6'd14;
  localparam logic [5:0] MDIO_TA_BITS       = 6'd2;
  localparam logic [5:0] MDIO_DATA_BITS     = 6'd16;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    FRAME,
    TA_WR,
    TA_RD,
    WR_DATA,
    RD_DATA,
    DONE
  } mdio_state_t;

  // Everything after the preamble that the master may drive, MSB first:
  // ST, OP, PHYAD, REGAD, write turnaround, write data.
  function automatic logic [31:0] mdio_cmd_word(input logic        write,
                                                input logic [4:0]  phy_addr,
                                                input logic [4:0]  reg_addr,
                                                input logic [15:0] data);
    return {MDIO_ST, (write ? MDIO_OP_WRITE : MDIO_OP_READ), phy_addr, reg_addr,
            MDIO_TA_WRITE, data};
  endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC prescaler: one bit is CLK_DIV cycles low followed by CLK_DIV cycles
// high. Held at count 0 with mdc low whenever the sequencer is not framing.
module mdio_mdc_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic bit_start,
  output logic sample,
  output logic bit_end
);

  localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       wrap;

  assign wrap = (cnt == CNT_MAX);

  // Prescale counter wraps at CLK_DIV-1 and toggles mdc on each wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= 8'd0;
      mdc <= 1'b0;
    end else if (wrap) begin
      cnt <= 8'd0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign bit_start = en && !mdc && (cnt == 8'd0);
  assign sample    = en && mdc && wrap;
  assign bit_end   = sample;

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: accepts one register read/write command
// at a time and serialises it onto MDC/MDIO, returning read data with a
// one-cycle valid strobe.
// Optional feature: define MDIO_PREAMBLE_SUPPRESS_EN to add cmd_no_preamble,
// which skips the 32-bit preamble for that command.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic        cmd_write,
  input  logic [15:0] cmd_data,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  input  logic        cmd_no_preamble,
`endif
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [15:0] rd_data,
  output logic        rd_data_valid,
  output logic        busy,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t
);

  mdio_state_t state, next_state;

  logic [1:0]  mdio_sync;
  logic [31:0] cmd_word;
  logic [31:0] tx_shift;
  logic [14:0] rx_shift;
  logic [5:0]  bit_cnt;
  logic        is_write;
  logic        accept;
  logic        skip_preamble;
  logic        bit_start;
  logic        sample;
  logic        bit_end;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign skip_preamble = cmd_no_preamble;
`else
  assign skip_preamble = 1'b0;
`endif

  assign cmd_ready     = (state == IDLE);
  assign accept        = cmd_valid && cmd_ready;
  assign busy          = (state != IDLE) && (state != DONE);
  assign rd_data_valid = (state == DONE) && !is_write;
  assign cmd_word      = mdio_cmd_word(cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_data);

  mdio_mdc_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_mdc_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (busy),
    .mdc      (mdc),
    .bit_start(bit_start),
    .sample   (sample),
    .bit_end  (bit_end)
  );

  // Two-flop synchroniser for the asynchronous MDIO pad input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdio_sync <= 2'b11;
    end else begin
      mdio_sync <= {mdio_sync[0], mdio_i};
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: sections advance at the end of their last bit
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = skip_preamble ? FRAME : PREAMBLE;
      PREAMBLE: if (bit_end && bit_cnt == MDIO_PREAMBLE_BITS) next_state = FRAME;
      FRAME:    if (bit_end && bit_cnt == MDIO_FRAME_BITS) next_state = is_write ? TA_WR : TA_RD;
      TA_WR:    if (bit_end && bit_cnt == MDIO_TA_BITS) next_state = WR_DATA;
      WR_DATA:  if (bit_end && bit_cnt == MDIO_DATA_BITS) next_state = DONE;
      TA_RD:    if (bit_end && bit_cnt == MDIO_TA_BITS) next_state = RD_DATA;
      RD_DATA:  if (bit_end && bit_cnt == MDIO_DATA_BITS) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Datapath: pin values are loaded at the edge that starts each bit so they
  // change only on the MDC falling edge (or straight out of idle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= 32'd0;
      rx_shift <= 15'd0;
      bit_cnt  <= 6'd0;
      is_write <= 1'b0;
      mdio_o   <= 1'b1;
      mdio_t   <= 1'b1;
      rd_data  <= 16'd0;
    end else if (accept) begin
      is_write <= cmd_write;
      bit_cnt  <= 6'd0;
      mdio_t   <= 1'b0;
      if (skip_preamble) begin
        mdio_o   <= cmd_word[31];
        tx_shift <= {cmd_word[30:0], 1'b0};
      end else begin
        mdio_o   <= 1'b1;
        tx_shift <= cmd_word;
      end
    end else begin
      if (bit_start) begin
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (sample && state == RD_DATA) begin
        rx_shift <= {rx_shift[13:0], mdio_sync[1]};
      end
      if (bit_end) begin
        if (next_state != state) begin
          bit_cnt <= 6'd0;
        end
        case (next_state)
          PREAMBLE: begin
            mdio_o <= 1'b1;
            mdio_t <= 1'b0;
          end
          FRAME, TA_WR, WR_DATA: begin
            mdio_o   <= tx_shift[31];
            mdio_t   <= 1'b0;
            tx_shift <= {tx_shift[30:0], 1'b0};
          end
          default: begin
            mdio_o <= 1'b1;
            mdio_t <= 1'b1;
          end
        endcase
        if (state == RD_DATA && next_state == DONE) begin
          rd_data <= {rx_shift, mdio_sync[1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master with CLK_DIV=4. Each command pushes its
// expected wire image, latency and read result; the monitor captures the
// MDIO bit stream at every MDC rise and compares when the frame completes.
module tb_mdio_master;

  localparam int CD    = 4;
  localparam int LIMIT = 2000;

  typedef struct {
    logic        wr;
    logic        no_pre;
    logic [63:0] exp_o;
    logic [63:0] exp_t;
    logic [15:0] rd;
  } sb_t;

  logic        clk;
  logic        rst;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic        cmd_write;
  logic [15:0] cmd_data;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic        cmd_no_preamble;
`endif
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic        busy;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_t;

  sb_t sb_q[$];

  int check_count = 0;
  int fail_count  = 0;
  int cyc         = 0;
  int acc_cyc     = 0;
  int done_cyc    = 0;
  int ready_cyc   = 0;
  int mon_bits    = 0;
  int run_len     = 0;
  int rdv_total   = 0;
  int done_seen   = 0;
  int reads_exp   = 0;
  int frames_exp  = 0;

  logic [63:0] cap_o;
  logic [63:0] cap_t;
  logic        busy_prev;
  logic        mdc_prev;
  logic        o_prev;

  mdio_master #(
    .CLK_DIV(CD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_phy_addr   (cmd_phy_addr),
    .cmd_reg_addr   (cmd_reg_addr),
    .cmd_write      (cmd_write),
    .cmd_data       (cmd_data),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    .cmd_no_preamble(cmd_no_preamble),
`endif
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .rd_data        (rd_data),
    .rd_data_valid  (rd_data_valid),
    .busy           (busy),
    .mdc            (mdc),
    .mdio_i         (mdio_i),
    .mdio_o         (mdio_o),
    .mdio_t         (mdio_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired checks=%0d", check_count);
    $fatal(1, "[TB] simulation did not finish in time");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Push the expected frame and present the command; returns right after the
  // accepting edge with cmd_valid still high. Called at posedge+1.
  task automatic applyStimulus(input logic wr, input logic [4:0] phy, input logic [4:0] ra,
                               input logic [15:0] data, input logic [15:0] phy_rd,
                               input logic no_pre);
    sb_t e;
    int  n;
    e.wr     = wr;
    e.no_pre = no_pre;
    e.exp_o  = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, ra,
                (wr ? 2'b10 : 2'b11), (wr ? data : 16'hFFFF)};
    e.exp_t  = wr ? 64'h0 : 64'h0000_0000_0003_FFFF;
    e.rd     = phy_rd;
    sb_q.push_back(e);
    if (cmd_ready) checkOutput("idle_mdc", 64'(mdc), 64'(0));
    cmd_phy_addr = phy;
    cmd_reg_addr = ra;
    cmd_write    = wr;
    cmd_data     = data;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    cmd_no_preamble = no_pre;
`endif
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("accept_timeout", 64'(cmd_ready), 64'(1));
      void'(sb_q.pop_back());
      cmd_valid = 1'b0;
    end else begin
      ready_cyc = cyc;
      frames_exp++;
      if (!wr) reads_exp++;
      @(posedge clk); #1;
    end
  endtask

  task automatic waitIdle();
    int n;
    cmd_valid = 1'b0;
    n = 0;
    while (!(cmd_ready && !busy) && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(cmd_ready && !busy)) checkOutput("idle_timeout", 64'(cmd_ready), 64'(1));
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor + PHY model: capture bits at MDC rises, drive read data after
  // each rise, check MDC shape and pin timing, score completed frames
  always @(negedge clk) begin : monitor
    sb_t         e;
    logic [63:0] mask;
    int          fidx;
    if (rst) begin
      mon_bits  = 0;
      busy_prev = 1'b0;
      mdc_prev  = 1'b0;
      o_prev    = mdio_o;
      run_len   = 0;
      mdio_i    = 1'b1;
    end else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (mdio_o !== o_prev)
        checkOutput("mdio_o_change_pos", 64'(!mdc && (mdc_prev || !busy_prev)), 64'(1));
      if (busy || busy_prev) begin
        if (!busy_prev) run_len = 1;
        else if (mdc == mdc_prev) run_len++;
        else begin
          checkOutput(mdc_prev ? "mdc_high_len" : "mdc_low_len", 64'(run_len), 64'(CD));
          run_len = 1;
        end
      end
      if (busy && mdc && !mdc_prev) begin
        cap_o = {cap_o[62:0], mdio_o};
        cap_t = {cap_t[62:0], mdio_t};
        fidx  = mon_bits;
        mon_bits++;
        mdio_i = 1'b1;
        if (sb_q.size() > 0 && !sb_q[0].wr) begin
          if (sb_q[0].no_pre) fidx = fidx + 32;
          if (fidx >= 48 && fidx <= 63) mdio_i = sb_q[0].rd[63 - fidx];
        end
      end
      if (rd_data_valid) rdv_total++;
      if (busy_prev && !busy) begin
        done_cyc = cyc;
        done_seen++;
        checkOutput("done_mdc", 64'(mdc), 64'(0));
        checkOutput("done_mdio_t", 64'(mdio_t), 64'(1));
        checkOutput("sb_pending", 64'(sb_q.size() > 0), 64'(1));
        if (sb_q.size() > 0) begin
          e    = sb_q.pop_front();
          mask = e.no_pre ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
          checkOutput("frame_bits", 64'(mon_bits), e.no_pre ? 64'(32) : 64'(64));
          checkOutput("frame_mdio_t", cap_t & mask, e.exp_t & mask);
          checkOutput("frame_mdio_o", cap_o & ~e.exp_t & mask, e.exp_o & ~e.exp_t & mask);
          checkOutput("latency", 64'(cyc - acc_cyc - 1), e.no_pre ? 64'(64 * CD) : 64'(128 * CD));
          checkOutput("rd_valid_at_done", 64'(rd_data_valid), 64'(!e.wr));
          if (!e.wr) checkOutput("rd_data", 64'(rd_data), 64'(e.rd));
        end
        mon_bits = 0;
      end
      busy_prev = busy;
      mdc_prev  = mdc;
      o_prev    = mdio_o;
    end
  end

  initial begin : sequencer
    int n;
    rst          = 1'b1;
    cmd_phy_addr = 5'd0;
    cmd_reg_addr = 5'd0;
    cmd_write    = 1'b0;
    cmd_data     = 16'd0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    cmd_no_preamble = 1'b0;
`endif
    cmd_valid    = 1'b0;
    mdio_i       = 1'b1;
    cap_o        = 64'd0;
    cap_t        = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mdc", 64'(mdc), 64'(0));
    checkOutput("rst_mdio_o", 64'(mdio_o), 64'(1));
    checkOutput("rst_mdio_t", 64'(mdio_t), 64'(1));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_rd_data", 64'(rd_data), 64'(0));
    checkOutput("rst_rd_valid", 64'(rd_data_valid), 64'(0));
    rst = 1'b0;
    checkOutput("ready_after_reset", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;

    $display("[TB] write PHY 1 reg 0 data 1140");
    applyStimulus(1'b1, 5'd1, 5'd0, 16'h1140, 16'h0000, 1'b0);
    waitIdle();

    $display("[TB] read PHY 3 reg 2, PHY returns 0141");
    applyStimulus(1'b0, 5'd3, 5'd2, 16'h0000, 16'h0141, 1'b0);
    waitIdle();

    $display("[TB] write PHY 31 reg 31 data a5c3");
    applyStimulus(1'b1, 5'd31, 5'd31, 16'hA5C3, 16'h0000, 1'b0);
    waitIdle();
    checkOutput("rd_data_held", 64'(rd_data), 64'(16'h0141));

    $display("[TB] back-to-back read then write");
    applyStimulus(1'b0, 5'd5, 5'd17, 16'h0000, 16'hBEEF, 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd9, 16'h0000, 16'h0000, 1'b0);
    checkOutput("b2b_accept_gap", 64'(ready_cyc), 64'(done_cyc + 1));
    waitIdle();
    checkOutput("rd_data_b2b", 64'(rd_data), 64'(16'hBEEF));

    $display("[TB] reset during read data bit 50");
    applyStimulus(1'b0, 5'd2, 5'd1, 16'h0000, 16'h1234, 1'b0);
    cmd_valid = 1'b0;
    n = 0;
    while (mon_bits < 51 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reached_bit_50", 64'(mon_bits), 64'(51));
    checkOutput("mdc_high_before_rst", 64'(mdc), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_mdc", 64'(mdc), 64'(0));
    checkOutput("abort_mdio_t", 64'(mdio_t), 64'(1));
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_rd_data", 64'(rd_data), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    frames_exp--;
    reads_exp--;
    checkOutput("abort_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;

    $display("[TB] write after abort");
    applyStimulus(1'b1, 5'd4, 5'd4, 16'h0F0F, 16'h0000, 1'b0);
    waitIdle();
    checkOutput("rd_data_after_abort", 64'(rd_data), 64'(0));

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    $display("[TB] write without preamble");
    applyStimulus(1'b1, 5'd1, 5'd0, 16'h1140, 16'h0000, 1'b1);
    waitIdle();
    $display("[TB] read without preamble");
    applyStimulus(1'b0, 5'd6, 5'd3, 16'h0000, 16'h8001, 1'b1);
    waitIdle();
`endif

    checkOutput("frames_done", 64'(done_seen), 64'(frames_exp));
    checkOutput("rd_valid_strobes", 64'(rdv_total), 64'(reads_exp));
    checkOutput("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
